// File: rtl/fpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fpu_ctrl_pkg
// Shared definitions for the float_to_int arbiter slice.
//   state_t   : arbiter FSM encoding (ARB=0, ACCEPT=1, ISSUE=2, WAIT_Z=3,
//               RETURN=4), 3 bits wide
//   N_REQ_MAX : largest supported requester count
// ---------------------------------------------------------------------------
package fpu_ctrl_pkg;

   localparam int N_REQ_MAX = 8;

   typedef enum logic [2:0] {
      ST_ARB    = 3'd0,
      ST_ACCEPT = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_WAIT_Z = 3'd3,
      ST_RETURN = 3'd4
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Searches the request vector
// starting at i_ptr and wrapping modulo N_REQ; reports the first set bit.
// Ports:
//   i_req   [N_REQ-1:0] request vector
//   i_ptr   [ID_W-1:0]  search start index (always < N_REQ)
//   o_found             any request set
//   o_index [ID_W-1:0]  winning index (0 when o_found is low)
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [ID_W-1:0]  i_ptr,
   output logic             o_found,
   output logic [ID_W-1:0]  o_index
);

   always_comb begin
      o_found = 1'b0;
      o_index = '0;
      for (int k = 0; k < N_REQ; k++) begin
         int c;
         c = int'(i_ptr) + k;
         // Manual wrap keeps this valid for non-power-of-two N_REQ.
         if (c >= N_REQ) c = c - N_REQ;
         if (!o_found && i_req[c]) begin
            o_found = 1'b1;
            o_index = ID_W'(c);
         end
      end
   end

endmodule

// File: rtl/float_to_int_arbiter.sv
// ---------------------------------------------------------------------------
// float_to_int_arbiter
// Round-robin arbiter sharing one unpipelined float_to_int converter between
// N_REQ requesters. One transaction in flight: grant, accept operand, issue
// to converter, collect result, return result to the owner only.
//
// Handshake: a word moves on the rising edge where stb and ack are both high;
// the side driving the ack/stb deasserts it on that same edge. Requesters
// hold req_a_stb until acked.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_a      [32*N_REQ]    operands, requester i at [32i+31:32i]
//   req_a_stb/req_a_ack      operand channel per requester (ack one-hot/zero)
//   rsp_z      [32]          result shared by all requesters
//   rsp_z_stb/rsp_z_ack      result channel per requester (stb one-hot/zero)
//   conv_a, conv_a_stb/ack   operand to converter
//   conv_z, conv_z_stb/ack   result from converter
//   busy                     high in every state except ARB
//   grant_id   [ID_W]        current owner, valid while busy
//   dbg_state  [3]           FSM state for observation
// All outputs are registers.
// ---------------------------------------------------------------------------
module float_to_int_arbiter
   import fpu_ctrl_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [32*N_REQ-1:0]   req_a,
   input  logic [N_REQ-1:0]      req_a_stb,
   output logic [N_REQ-1:0]      req_a_ack,
   output logic [31:0]           rsp_z,
   output logic [N_REQ-1:0]      rsp_z_stb,
   input  logic [N_REQ-1:0]      rsp_z_ack,
   output logic [31:0]           conv_a,
   output logic                  conv_a_stb,
   input  logic                  conv_a_ack,
   input  logic [31:0]           conv_z,
   input  logic                  conv_z_stb,
   output logic                  conv_z_ack,
   output logic                  busy,
   output logic [ID_W-1:0]       grant_id,
   output logic [2:0]            dbg_state
);

   state_t            r_state, w_nx_state;
   logic [ID_W-1:0]   r_ptr, w_nx_ptr;
   logic [ID_W-1:0]   r_grant, w_nx_grant;
   logic [31:0]       r_a_reg, w_nx_a;
   logic [31:0]       r_z_reg, w_nx_z;
   logic [N_REQ-1:0]  r_req_a_ack, w_nx_req_a_ack;
   logic [N_REQ-1:0]  r_rsp_z_stb, w_nx_rsp_z_stb;
   logic              r_conv_a_stb, r_conv_z_ack, r_busy;

   logic              w_found;
   logic [ID_W-1:0]   w_pick;
   logic [31:0]       w_a_slice;
   logic [N_REQ-1:0]  w_grant_oh;

   rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr_pick (
      .i_req   (req_a_stb),
      .i_ptr   (r_ptr),
      .o_found (w_found),
      .o_index (w_pick)
   );

   // Operand slice of the current owner.
   always_comb begin
      w_a_slice = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (i == int'(r_grant)) w_a_slice = req_a[32*i +: 32];
      end
   end

   // Next-state logic.
   always_comb begin
      w_nx_state = r_state;
      w_nx_ptr   = r_ptr;
      w_nx_grant = r_grant;
      w_nx_a     = r_a_reg;
      w_nx_z     = r_z_reg;
      case (r_state)
         ST_ARB: begin
            if (w_found) begin
               w_nx_state = ST_ACCEPT;
               w_nx_grant = w_pick;
               w_nx_ptr   = (w_pick == ID_W'(N_REQ - 1)) ? '0 : w_pick + 1'b1;
            end
         end
         ST_ACCEPT: begin
            if ((r_req_a_ack & req_a_stb) != '0) begin
               w_nx_a     = w_a_slice;
               w_nx_state = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (r_conv_a_stb && conv_a_ack) w_nx_state = ST_WAIT_Z;
         end
         ST_WAIT_Z: begin
            if (r_conv_z_ack && conv_z_stb) begin
               w_nx_z     = conv_z;
               w_nx_state = ST_RETURN;
            end
         end
         ST_RETURN: begin
            // Only the owner's ack bit can match r_rsp_z_stb.
            if ((r_rsp_z_stb & rsp_z_ack) != '0) w_nx_state = ST_ARB;
         end
         default: w_nx_state = ST_ARB;
      endcase
   end

   // Output flags are decoded from the next state so that they are registered
   // and fall on the same edge that completes the handshake.
   always_comb begin
      w_grant_oh = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (i == int'(w_nx_grant)) w_grant_oh[i] = 1'b1;
      end
      w_nx_req_a_ack = (w_nx_state == ST_ACCEPT) ? w_grant_oh : '0;
      w_nx_rsp_z_stb = (w_nx_state == ST_RETURN) ? w_grant_oh : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_ARB;
         r_ptr        <= '0;
         r_grant      <= '0;
         r_a_reg      <= '0;
         r_z_reg      <= '0;
         r_req_a_ack  <= '0;
         r_rsp_z_stb  <= '0;
         r_conv_a_stb <= 1'b0;
         r_conv_z_ack <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_nx_state;
         r_ptr        <= w_nx_ptr;
         r_grant      <= w_nx_grant;
         r_a_reg      <= w_nx_a;
         r_z_reg      <= w_nx_z;
         r_req_a_ack  <= w_nx_req_a_ack;
         r_rsp_z_stb  <= w_nx_rsp_z_stb;
         r_conv_a_stb <= (w_nx_state == ST_ISSUE);
         r_conv_z_ack <= (w_nx_state == ST_WAIT_Z);
         r_busy       <= (w_nx_state != ST_ARB);
      end
   end

   assign req_a_ack  = r_req_a_ack;
   assign rsp_z      = r_z_reg;
   assign rsp_z_stb  = r_rsp_z_stb;
   assign conv_a     = r_a_reg;
   assign conv_a_stb = r_conv_a_stb;
   assign conv_z_ack = r_conv_z_ack;
   assign busy       = r_busy;
   assign grant_id   = r_grant;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_float_to_int_arbiter.sv
// ---------------------------------------------------------------------------
// tb_float_to_int_arbiter
// Bench for float_to_int_arbiter with a behavioural float_to_int converter
// attached. Expected responses ({owner id, result}) are queued when stimulus
// is issued; a monitor pops and compares each time a response appears.
// ---------------------------------------------------------------------------
module tb_float_to_int_arbiter;

   localparam int N_REQ = 4;
   localparam int ID_W  = 2;
   localparam int W     = ID_W + 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [32*N_REQ-1:0] req_a = '0;
   logic [N_REQ-1:0]    req_a_stb = '0;
   logic [N_REQ-1:0]    req_a_ack;
   logic [31:0]         rsp_z;
   logic [N_REQ-1:0]    rsp_z_stb;
   logic [N_REQ-1:0]    rsp_z_ack = '0;
   logic [31:0]         conv_a;
   logic                conv_a_stb;
   logic                conv_a_ack;
   logic [31:0]         conv_z;
   logic                conv_z_stb;
   logic                conv_z_ack;
   logic                busy;
   logic [ID_W-1:0]     grant_id;
   logic [2:0]          dbg_state;

   float_to_int_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_a      (req_a),
      .req_a_stb  (req_a_stb),
      .req_a_ack  (req_a_ack),
      .rsp_z      (rsp_z),
      .rsp_z_stb  (rsp_z_stb),
      .rsp_z_ack  (rsp_z_ack),
      .conv_a     (conv_a),
      .conv_a_stb (conv_a_stb),
      .conv_a_ack (conv_a_ack),
      .conv_z     (conv_z),
      .conv_z_stb (conv_z_stb),
      .conv_z_ack (conv_z_ack),
      .busy       (busy),
      .grant_id   (grant_id),
      .dbg_state  (dbg_state)
   );

   // ---------------- converter model ----------------
   function automatic logic [31:0] f2i(input logic [31:0] a);
      int          e;
      logic [31:0] m;
      logic [31:0] r;
      e = int'(a[30:23]) - 127;
      m = {8'h00, 1'b1, a[22:0]};
      if (e < 0) return 32'h0;
      if (e >= 31) return 32'h8000_0000;
      if (e >= 23) r = m << (e - 23);
      else         r = m >> (23 - e);
      return a[31] ? (~r + 32'd1) : r;
   endfunction

   logic        cv_busy;
   int          cv_cnt;
   logic [31:0] cv_z;
   assign conv_z = cv_z;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         conv_a_ack <= 1'b0;
         conv_z_stb <= 1'b0;
         cv_busy    <= 1'b0;
         cv_cnt     <= 0;
         cv_z       <= 32'h0;
      end else if (cv_busy) begin
         if (cv_cnt == 0) begin
            cv_busy    <= 1'b0;
            conv_z_stb <= 1'b1;
         end else begin
            cv_cnt <= cv_cnt - 1;
         end
      end else if (conv_z_stb) begin
         if (conv_z_ack) conv_z_stb <= 1'b0;
      end else begin
         conv_a_ack <= 1'b1;
         if (conv_a_ack && conv_a_stb) begin
            conv_a_ack <= 1'b0;
            cv_z       <= f2i(conv_a);
            cv_cnt     <= 3;
            cv_busy    <= 1'b1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", name, act, exp);
   endfunction

   task automatic expect_rsp(input int id, input logic [31:0] z);
      exp_q.push_back({ID_W'(id), z});
   endtask

   // ---------------- driver tasks ----------------
   task automatic offer(input int id, input logic [31:0] v);
      req_a[32*id +: 32] = v;
      req_a_stb[id]      = 1'b1;
   endtask

   int hold_cnt[N_REQ] = '{default: 0};

   // Requester side of both channels: drop req_a_stb after the accepting
   // edge, ack responses unless a hold count is pending.
   initial begin
      logic [N_REQ-1:0] drop;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N_REQ; i++) begin
            rsp_z_ack[i] = rsp_z_stb[i] && (hold_cnt[i] == 0);
            if (rsp_z_stb[i] && hold_cnt[i] > 0) hold_cnt[i]--;
         end
         drop = req_a_stb & req_a_ack;
         @(posedge clk);
         #1;
         req_a_stb = req_a_stb & ~drop;
      end
   end

   // ---------------- monitor ----------------
   initial begin
      logic [N_REQ-1:0] prev;
      logic [W-1:0]     e;
      prev = '0;
      forever begin
         @(negedge clk);
         if (rsp_z_stb != '0 && prev == '0) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", {28'h0, rsp_z_stb}, 32'h0);
            end else begin
               e = exp_q.pop_front();
               check("rsp_stb", {28'h0, rsp_z_stb}, {28'h0, 4'b0001 << e[W-1:32]});
               check("rsp_z", rsp_z, e[31:0]);
               check("rsp_grant_id", {30'h0, grant_id}, {30'h0, e[W-1:32]});
            end
         end
         prev = rsp_z_stb;
      end
   end

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && !busy && rsp_z_stb == '0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'h0, n < 400}, 32'h1);
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_req_a_ack"}, {28'h0, req_a_ack}, 32'h0);
      check({name, "_rsp_z_stb"}, {28'h0, rsp_z_stb}, 32'h0);
      check({name, "_conv_a_stb"}, {31'h0, conv_a_stb}, 32'h0);
      check({name, "_conv_z_ack"}, {31'h0, conv_z_ack}, 32'h0);
      check({name, "_busy"}, {31'h0, busy}, 32'h0);
      check({name, "_state"}, {29'h0, dbg_state}, 32'h0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      check("reset_rsp_z", rsp_z, 32'h0);
      check("reset_grant_id", {30'h0, grant_id}, 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single requests, including truncation, saturation and zero.
      expect_rsp(2, 32'h0000_0001); offer(2, 32'h3F80_0000); wait_done("single_r2");
      expect_rsp(0, 32'hFFFF_FFFE); offer(0, 32'hC020_0000); wait_done("neg_trunc");
      expect_rsp(1, 32'h8000_0000); offer(1, 32'h4F00_0000); wait_done("saturate");
      expect_rsp(3, 32'h0000_0000); offer(3, 32'h0000_0000); wait_done("zero");

      // Round robin from a fresh reset, all four requesting.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      expect_rsp(0, 32'd1); expect_rsp(1, 32'd2);
      expect_rsp(2, 32'd3); expect_rsp(3, 32'd4);
      offer(0, 32'h3F80_0000); offer(1, 32'h4000_0000);
      offer(2, 32'h4040_0000); offer(3, 32'h4080_0000);
      n = 0;
      while (req_a_stb[1] && n < 200) begin @(negedge clk); n++; end
      check("rr_r1_accept", {31'h0, n < 200}, 32'h1);
      offer(1, 32'h40A0_0000);
      n = 0;
      while (req_a_stb[3] && n < 200) begin @(negedge clk); n++; end
      check("rr_r3_accept", {31'h0, n < 200}, 32'h1);
      offer(0, 32'h40C0_0000); offer(2, 32'h40E0_0000); offer(3, 32'h4100_0000);
      expect_rsp(0, 32'd6); expect_rsp(1, 32'd5);
      expect_rsp(2, 32'd7); expect_rsp(3, 32'd8);
      wait_done("round_robin");

      // Back-pressure: owner 3 withholds rsp_z_ack while 1 waits.
      expect_rsp(3, 32'd123); expect_rsp(1, 32'd1);
      hold_cnt[3] = 20;
      offer(3, 32'h42F6_0000);
      n = 0;
      while (!rsp_z_stb[3] && n < 200) begin @(negedge clk); n++; end
      check("bp_rsp_seen", {31'h0, n < 200}, 32'h1);
      offer(1, 32'h3FC0_0000);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         check("bp_rsp_hold", {31'h0, rsp_z_stb[3]}, 32'h1);
         check("bp_no_ack1", {31'h0, req_a_ack[1]}, 32'h0);
      end
      wait_done("back_pressure");

      // Reset during WAIT_Z: the in-flight transaction must vanish.
      offer(2, 32'h3F80_0000);
      n = 0;
      while (dbg_state != 3'd3 && n < 200) begin @(negedge clk); n++; end
      check("mid_reach_wait_z", {31'h0, n < 200}, 32'h1);
      #1 rst = 1'b1;
      #1 check_idle_outputs("mid_reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      // Pointer back at 0: requester 1 wins over 3.
      expect_rsp(1, 32'd2); expect_rsp(3, 32'd4);
      offer(1, 32'h4000_0000); offer(3, 32'h4080_0000);
      wait_done("after_reset");
      repeat (10) @(negedge clk);
      check("queue_empty", exp_q.size(), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1);
   end

endmodule
